// File: rtl/bcd_pkg.sv
// Shared types and seven-segment constants for the BCD display scanner.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package bcd_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned DATA_W     = NUM_DIGITS * BCD_W;

  typedef logic [BCD_W-1:0] bcd_t;
  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_DASH  = 7'b0111111;
  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Digit data in, display pins out, between the counter bank and the scanner.
interface bcd_display_scanner_if;
  import bcd_pkg::*;

  logic                  Enable;
  logic [DATA_W-1:0]     DataIn;
  logic [NUM_DIGITS-1:0] DpIn;
  logic                  BlankLZ;
  logic [NUM_DIGITS-1:0] An;
  seg_t                  Seg;
  logic                  Dp;
  logic                  Frame;

  modport master (
    output Enable, DataIn, DpIn, BlankLZ,
    input  An, Seg, Dp, Frame
  );

  modport slave (
    input  Enable, DataIn, DpIn, BlankLZ,
    output An, Seg, Dp, Frame
  );
endinterface

// File: rtl/bcd_to_seg.sv
// BCD digit to active-low seven-segment pattern; codes A-F show a dash.
module bcd_to_seg
  import bcd_pkg::*;
(
  input  bcd_t bcd,
  output seg_t seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode display; digits are
// snapshotted once per frame so a counting source never tears mid-scan.
module bcd_display_scanner
  import bcd_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  bcd_display_scanner_if.slave  bus
);

  localparam int unsigned CNT_W = (REFRESH_DIV < 2) ? 1 : $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  if (REFRESH_DIV < 2) begin : g_div_check
    $error("bcd_display_scanner: REFRESH_DIV must be >= 2");
  end

  logic [CNT_W-1:0]              ref_cnt;
  logic [1:0]                    idx;
  bcd_t [NUM_DIGITS-1:0]         snap;
  logic [NUM_DIGITS-1:0]         snap_dp;
  logic                          primed;

  logic                          tick_c;
  logic                          load_c;
  logic [NUM_DIGITS-1:0]         lead_zero_c;
  logic                          blank_c;
  seg_t                          dec_seg_c;
  logic [NUM_DIGITS-1:0]         an_sel_c;

  assign tick_c = bus.Enable && (ref_cnt == CNT_LAST);
  assign load_c = bus.Enable && (!primed || (tick_c && idx == 2'd3));

  // lead_zero_c[k]: snapshot digits 3..k are all zero; digit 0 never blanks.
  always_comb begin
    lead_zero_c    = '0;
    lead_zero_c[3] = (snap[3] == 4'd0);
    lead_zero_c[2] = lead_zero_c[3] && (snap[2] == 4'd0);
    lead_zero_c[1] = lead_zero_c[2] && (snap[1] == 4'd0);
  end

  assign blank_c  = bus.BlankLZ && lead_zero_c[idx];
  assign an_sel_c = ~(4'b0001 << idx);

  bcd_to_seg u_dec (
    .bcd (snap[idx]),
    .seg (dec_seg_c)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ref_cnt   <= '0;
      idx       <= '0;
      snap      <= '0;
      snap_dp   <= '0;
      primed    <= 1'b0;
      bus.An    <= AN_OFF;
      bus.Seg   <= SEG_BLANK;
      bus.Dp    <= 1'b1;
      bus.Frame <= 1'b0;
    end else if (bus.Enable) begin
      if (load_c) begin
        snap    <= bus.DataIn;
        snap_dp <= bus.DpIn;
        primed  <= 1'b1;
      end
      if (tick_c) begin
        ref_cnt <= '0;
        idx     <= idx + 2'd1;
      end else begin
        ref_cnt <= ref_cnt + CNT_W'(1);
      end
      bus.An    <= an_sel_c;
      bus.Seg   <= blank_c ? SEG_BLANK : dec_seg_c;
      bus.Dp    <= ~snap_dp[idx];
      bus.Frame <= load_c;
    end else begin
      // Frozen: scan state holds, display dark.
      bus.An    <= AN_OFF;
      bus.Seg   <= SEG_BLANK;
      bus.Dp    <= 1'b1;
      bus.Frame <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with REFRESH_DIV=4.
module tb_bcd_display_scanner;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  bcd_display_scanner_if bus();

  bcd_display_scanner #(.REFRESH_DIV(4)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] an, input logic [6:0] seg, input logic dp);
    check({tag, "_an"},  16'(bus.An),  16'(an));
    check({tag, "_seg"}, 16'(bus.Seg), 16'(seg));
    check({tag, "_dp"},  16'(bus.Dp),  16'(dp));
  endtask

  task automatic wait_frame(input string tag);
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (bus.Frame) break;
    end
    check({tag, "_frame"}, 16'(bus.Frame), 16'd1);
  endtask

  // Wait for the next snapshot, then check each digit on its first cycle.
  task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpn);
    wait_frame(tag);
    step(1); chk_out({tag, "_d0"}, 4'b1110, s0, dpn[0]);
    step(4); chk_out({tag, "_d1"}, 4'b1101, s1, dpn[1]);
    step(4); chk_out({tag, "_d2"}, 4'b1011, s2, dpn[2]);
    step(4); chk_out({tag, "_d3"}, 4'b0111, s3, dpn[3]);
  endtask

  initial begin
    rst         = 1'b0;
    bus.Enable  = 1'b1;
    bus.DataIn  = 16'h9999;
    bus.DpIn    = 4'b0000;
    bus.BlankLZ = 1'b0;

    // Reset held with enable on
    step(1);
    chk_out("rst1", 4'b1111, 7'b1111111, 1'b1);
    check("rst1_frame", 16'(bus.Frame), 16'd0);
    step(1);
    chk_out("rst2", 4'b1111, 7'b1111111, 1'b1);
    check("rst2_frame", 16'(bus.Frame), 16'd0);

    // Basic scan, with a mid-frame data change for coherence
    bus.DataIn = 16'h1234;
    bus.DpIn   = 4'b0010;
    rst        = 1'b1;
    step(1);
    check("e1_frame", 16'(bus.Frame), 16'd1);
    check("e1_an", 16'(bus.An), 16'hE);
    step(1);
    chk_out("e2", 4'b1110, 7'b0011001, 1'b1);
    check("e2_frame", 16'(bus.Frame), 16'd0);
    step(2);
    chk_out("e4", 4'b1110, 7'b0011001, 1'b1);
    step(1);
    chk_out("e5", 4'b1101, 7'b0110000, 1'b0);
    step(1);
    bus.DataIn = 16'h5678;
    check("e6_an", 16'(bus.An), 16'hD);
    step(2);
    chk_out("e8", 4'b1101, 7'b0110000, 1'b0);
    step(1);
    chk_out("e9", 4'b1011, 7'b0100100, 1'b1);
    step(4);
    chk_out("e13", 4'b0111, 7'b1111001, 1'b1);
    step(3);
    check("e16_frame", 16'(bus.Frame), 16'd1);
    check("e16_an", 16'(bus.An), 16'h7);
    step(1);
    chk_out("e17", 4'b1110, 7'b0000000, 1'b1);
    check("e17_frame", 16'(bus.Frame), 16'd0);

    // Leading-zero blanking; Dp still shown on a blanked digit
    bus.BlankLZ = 1'b1;
    bus.DataIn  = 16'h0070;
    bus.DpIn    = 4'b1000;
    check_frame("lz0070", 7'b1000000, 7'b1111000, 7'b1111111, 7'b1111111, 4'b0111);
    bus.DataIn = 16'h0000;
    bus.DpIn   = 4'b0000;
    check_frame("lz0000", 7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111, 4'b1111);
    bus.DataIn = 16'h0100;
    check_frame("lz0100", 7'b1000000, 7'b1000000, 7'b1111001, 7'b1111111, 4'b1111);

    // Invalid codes decode to a dash
    bus.BlankLZ = 1'b0;
    bus.DataIn  = 16'h00AF;
    check_frame("inv", 7'b0111111, 7'b0111111, 7'b1000000, 7'b1000000, 4'b1111);

    // Enable dropped during digit 1's second cycle, then resumed
    wait_frame("en");
    step(6);
    check("en_d1_an", 16'(bus.An), 16'hD);
    bus.Enable = 1'b0;
    step(1);
    chk_out("dis1", 4'b1111, 7'b1111111, 1'b1);
    check("dis1_frame", 16'(bus.Frame), 16'd0);
    step(2);
    check("dis3_an", 16'(bus.An), 16'hF);
    bus.Enable = 1'b1;
    step(1);
    chk_out("res1", 4'b1101, 7'b0111111, 1'b1);
    step(1);
    check("res2_an", 16'(bus.An), 16'hD);
    step(1);
    chk_out("res3", 4'b1011, 7'b1000000, 1'b1);

    // Reset mid-digit, then restart from digit 0 with a fresh frame
    step(1);
    rst = 1'b0;
    step(1);
    chk_out("mrst", 4'b1111, 7'b1111111, 1'b1);
    check("mrst_frame", 16'(bus.Frame), 16'd0);
    rst = 1'b1;
    step(1);
    check("rel1_frame", 16'(bus.Frame), 16'd1);
    check("rel1_an", 16'(bus.An), 16'hE);
    step(1);
    chk_out("rel2", 4'b1110, 7'b0111111, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
